// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Turns raw, bouncing, active-low push-button pins into clean synchronous
//   events for the scope control logic. Every key is handled independently:
//   a debounced level, one-cycle press/release strobes, a long-press strobe
//   and, optionally, an auto-repeat strobe while the key stays held.
//
//   Optional feature macro: KEY_AUTOREPEAT_EN
//     defined   -> key_repeat pulses every REPEAT_MS ms after key_long
//     undefined -> key_repeat is constant 0 and no repeat counters exist
//
// Parameters
//   NUM_KEYS     number of independent keys
//   CLK_HZ       sys_clk frequency in Hz (multiple of 1000)
//   DEBOUNCE_MS  stable time needed to accept a press or a release (>= 1)
//   LONG_MS      hold time, from accepted press, before key_long (> DEBOUNCE_MS)
//   REPEAT_MS    auto-repeat period after key_long (>= 1)
//
// Ports
//   sys_clk      in   system clock
//   sys_rst_n    in   asynchronous active-low reset
//   key_n        in   [NUM_KEYS] raw button pins, 0 = pressed, asynchronous
//   key_level    out  [NUM_KEYS] debounced state, 1 = pressed
//   key_press    out  [NUM_KEYS] 1-cycle strobe on accepted press
//   key_release  out  [NUM_KEYS] 1-cycle strobe on accepted release
//   key_long     out  [NUM_KEYS] 1-cycle strobe once per hold at LONG_MS
//   key_repeat   out  [NUM_KEYS] 1-cycle strobe every REPEAT_MS after key_long
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int NUM_KEYS    = 3,
  parameter int CLK_HZ      = 24_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);

  // Millisecond prescaler geometry
  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  // Per-key ms counter; it must be able to hold LONG_MS itself because the
  // hold count saturates there, which is also what makes key_long one-shot.
  localparam int CW = $clog2(LONG_MS + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_MS - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - 1);
  localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_MS);

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = (REPEAT_MS > 1) ? $clog2(REPEAT_MS) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_MS - 1);
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } key_state_t;

  // ---------------------------------------------------------------------------
  // Shared free-running ms prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre_cnt;
  logic          ms_tick;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign ms_tick = (pre_cnt == PRE_LAST);

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers; they reset to 1 so every key starts released.
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] sync_1;
  logic [NUM_KEYS-1:0] sync_2;
  logic [NUM_KEYS-1:0] pressed;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_1 <= '1;
      sync_2 <= '1;
    end else begin
      sync_1 <= key_n;
      sync_2 <= sync_1;
    end
  end

  assign pressed = ~sync_2;

  // ---------------------------------------------------------------------------
  // Per-key debounce / hold state machines
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_state_t    state;
    key_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] rcnt;
    logic [CW-1:0] rcnt_nxt;
    logic          press_q;
    logic          press_nxt;
    logic          release_q;
    logic          release_nxt;
    logic          long_q;
    logic          long_nxt;
    logic          level_q;
    logic          level_nxt;
    logic          pr;

    assign pr = pressed[i];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state     <= IDLE;
        cnt       <= '0;
        rcnt      <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        level_q   <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        rcnt      <= rcnt_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
        long_q    <= long_nxt;
        level_q   <= level_nxt;
      end
    end

    // cnt is the press-debounce count in PRESS_DB and the hold count in
    // HELD/REL_DB; rcnt is only the release-debounce count. Keeping them
    // apart lets a release bounce leave the hold timing untouched.
    always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      rcnt_nxt    = rcnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      level_nxt   = level_q;

      unique case (state)
        IDLE: begin
          if (pr) begin
            state_nxt = PRESS_DB;
            cnt_nxt   = '0;
          end
        end

        PRESS_DB: begin
          if (!pr) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (ms_tick) begin
            if (cnt == DEB_LAST) begin
              state_nxt = HELD;
              cnt_nxt   = '0;
              press_nxt = 1'b1;
              level_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
        end

        HELD: begin
          if (!pr) begin
            state_nxt = REL_DB;
            rcnt_nxt  = '0;
          end else if (ms_tick && (cnt != LONG_SAT)) begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == LONG_LAST) begin
              long_nxt = 1'b1;
            end
          end
        end

        REL_DB: begin
          if (pr) begin
            state_nxt = HELD;
          end else if (ms_tick) begin
            if (rcnt == DEB_LAST) begin
              state_nxt   = IDLE;
              cnt_nxt     = '0;
              rcnt_nxt    = '0;
              release_nxt = 1'b1;
              level_nxt   = 1'b0;
            end else begin
              rcnt_nxt = rcnt + CW'(1);
            end
          end
        end

        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          rcnt_nxt  = '0;
        end
      endcase
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;

`ifdef KEY_AUTOREPEAT_EN
    // The repeat counter only advances on ticks that the saturated hold count
    // would otherwise ignore, so the tick that fires key_long never counts
    // and the first repeat lands a full REPEAT_MS later. REL_DB simply does
    // not advance it, which gives the pause-on-bounce behaviour for free.
    logic [RW-1:0] rep_cnt;
    logic          repeat_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        rep_cnt  <= '0;
        repeat_q <= 1'b0;
      end else begin
        repeat_q <= 1'b0;
        if (state == IDLE) begin
          rep_cnt <= '0;
        end else if ((state == HELD) && pr && ms_tick && (cnt == LONG_SAT)) begin
          if (rep_cnt == REP_LAST) begin
            rep_cnt  <= '0;
            repeat_q <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + RW'(1);
          end
        end
      end
    end

    assign key_repeat[i] = repeat_q;
`else
    assign key_repeat[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//   Self-checking bench for key_debounce with a 10 kHz clock (ms tick every
//   10 cycles), DEBOUNCE_MS=3, LONG_MS=10, REPEAT_MS=4, three keys.
//   Directed scenarios are followed by a randomized bounce phase; every cycle
//   all outputs are compared against a reference model that reasons in terms
//   of "how many ms ticks has the synchronized key level been stable".
// -----------------------------------------------------------------------------
module tb_key_debounce;

  localparam int NK       = 3;
  localparam int TICK_DIV = 10;
  localparam int DEB      = 3;
  localparam int LONG     = 10;
  localparam int REP      = 4;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [NK-1:0] key_n     = '1;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;
  logic [NK-1:0] key_repeat;

  key_debounce #(
    .NUM_KEYS   (NK),
    .CLK_HZ     (TICK_DIV * 1000),
    .DEBOUNCE_MS(DEB),
    .LONG_MS    (LONG),
    .REPEAT_MS  (REP)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_repeat (key_repeat)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  bit [NK-1:0] m_s1, m_s2;
  bit [NK-1:0] m_prev;
  bit [NK-1:0] m_level, m_press, m_rel, m_long, m_rep;
  int          m_deb  [NK];
  int          m_hold [NK];
  int          m_rpt  [NK];
  int          m_phase;

  task automatic model_reset();
    m_s1    = '1;
    m_s2    = '1;
    m_prev  = '0;
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    m_rep   = '0;
    m_phase = 0;
    for (int k = 0; k < NK; k++) begin
      m_deb[k]  = 0;
      m_hold[k] = 0;
      m_rpt[k]  = 0;
    end
  endtask

  // One clock edge of the model. A tick only counts toward a level change
  // when the synchronized key has sat at the new level for at least the
  // previous cycle too; the hold timer only counts while the key has been
  // steadily down. Events appear on the outputs the cycle after their tick.
  task automatic model_edge();
    bit tick;
    bit p;
    tick    = (m_phase == TICK_DIV - 1);
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    m_rep   = '0;
    for (int k = 0; k < NK; k++) begin
      p = ~m_s2[k];
      if (p != m_level[k]) begin
        if ((m_prev[k] == p) && tick) begin
          m_deb[k]++;
          if (m_deb[k] == DEB) begin
            m_deb[k]   = 0;
            m_level[k] = p;
            m_hold[k]  = 0;
            m_rpt[k]   = 0;
            if (p) m_press[k] = 1'b1;
            else   m_rel[k]   = 1'b1;
          end
        end
      end else begin
        m_deb[k] = 0;
        if (m_level[k] && m_prev[k] && tick) begin
          if (m_hold[k] < LONG) begin
            m_hold[k]++;
            if (m_hold[k] == LONG) m_long[k] = 1'b1;
          end else begin
`ifdef KEY_AUTOREPEAT_EN
            m_rpt[k]++;
            if (m_rpt[k] == REP) begin
              m_rpt[k] = 0;
              m_rep[k] = 1'b1;
            end
`endif
          end
        end
      end
      m_prev[k] = p;
    end
    m_phase = (m_phase + 1) % TICK_DIV;
    m_s2    = m_s1;
    m_s1    = key_n;
  endtask

  task automatic checkOutput();
    total++;
    assert (key_level === m_level) else begin
      bad++;
      $error("[TB] FAIL level cyc=%0d got=%b want=%b", cyc, key_level, m_level);
    end
    total++;
    assert (key_press === m_press) else begin
      bad++;
      $error("[TB] FAIL press cyc=%0d got=%b want=%b", cyc, key_press, m_press);
    end
    total++;
    assert (key_release === m_rel) else begin
      bad++;
      $error("[TB] FAIL release cyc=%0d got=%b want=%b", cyc, key_release, m_rel);
    end
    total++;
    assert (key_long === m_long) else begin
      bad++;
      $error("[TB] FAIL long cyc=%0d got=%b want=%b", cyc, key_long, m_long);
    end
    total++;
    assert (key_repeat === m_rep) else begin
      bad++;
      $error("[TB] FAIL repeat cyc=%0d got=%b want=%b", cyc, key_repeat, m_rep);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    if (!sys_rst_n) model_reset();
    else            model_edge();
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [NK-1:0] kn, input int n);
    key_n = kn;
    for (int s = 0; s < n; s++) step();
  endtask

  task automatic resetPulse(input int n);
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput();
    for (int s = 0; s < n; s++) step();
    sys_rst_n = 1'b1;
  endtask

  // Press key k and watch n cycles: latency to the first press strobe
  // (-1 if none) and total number of press strobes on that key.
  task automatic watchPress(input int k, input int n, output int lat, output int cnt);
    lat = -1;
    cnt = 0;
    key_n[k] = 1'b0;
    for (int s = 1; s <= n; s++) begin
      step();
      if (key_press[k]) begin
        cnt++;
        if (lat < 0) lat = s;
      end
    end
  endtask

  int lat, npress, t0, t2, quiet;
  int rem[NK];

  initial begin
    // Reset with all keys released
    key_n = '1;
    resetPulse(5);
    applyStimulus(3'b111, 20);

    // Clean press of key 0: one strobe after sync + debounce + register delay
    watchPress(0, 40, lat, npress);
    total++;
    assert (lat >= 2 + (DEB - 1) * TICK_DIV + 1 && lat <= 2 + DEB * TICK_DIV + 1) else begin
      bad++;
      $error("[TB] FAIL press0_latency got=%0d want=23..33", lat);
    end
    total++;
    assert (npress == 1) else begin
      bad++;
      $error("[TB] FAIL press0_count got=%0d want=1", npress);
    end
    // Keep holding to 150 cycles (long press), then release
    applyStimulus(3'b110, 110);
    applyStimulus(3'b111, 50);

    // Short press: released before LONG_MS, no key_long
    applyStimulus(3'b110, 60);
    applyStimulus(3'b111, 50);

    // Key 1 chattering every 7 cycles: never accepted
    quiet = 0;
    for (int t = 0; t < 200; t++) begin
      if (t % 7 == 0) key_n[1] = ~key_n[1];
      step();
      if (key_press[1] || key_level[1] || key_release[1]) quiet++;
    end
    total++;
    assert (quiet == 0) else begin
      bad++;
      $error("[TB] FAIL chatter_quiet got=%0d want=0", quiet);
    end
    watchPress(1, 50, lat, npress);
    total++;
    assert (npress == 1) else begin
      bad++;
      $error("[TB] FAIL press1_count got=%0d want=1", npress);
    end
    applyStimulus(3'b111, 50);

    // Release glitch while held
    applyStimulus(3'b110, 50);
    applyStimulus(3'b111, 15);
    applyStimulus(3'b110, 120);
    applyStimulus(3'b111, 50);

    // Keys 0 and 2 pressed together
    key_n = 3'b010;
    t0 = -1;
    t2 = -1;
    quiet = 0;
    for (int s = 0; s < 45; s++) begin
      step();
      if (key_press[0] && t0 < 0) t0 = s;
      if (key_press[2] && t2 < 0) t2 = s;
      if (key_press[1]) quiet++;
    end
    total++;
    assert (t0 >= 0 && t0 == t2 && quiet == 0) else begin
      bad++;
      $error("[TB] FAIL dual_press got=%0d/%0d/%0d want=same,same,0", t0, t2, quiet);
    end
    applyStimulus(3'b111, 50);

    // Long hold for auto-repeat
    applyStimulus(3'b110, 200);
    applyStimulus(3'b111, 50);

    // Reset while held, then a fresh press after deassert
    applyStimulus(3'b110, 60);
    resetPulse(3);
    npress = 0;
    lat = -1;
    for (int s = 1; s <= 45; s++) begin
      step();
      if (key_press[0]) begin
        npress++;
        if (lat < 0) lat = s;
      end
    end
    total++;
    assert (npress == 1 && lat >= 20 && lat <= 36) else begin
      bad++;
      $error("[TB] FAIL press_after_reset got=%0d@%0d want=1@20..36", npress, lat);
    end
    applyStimulus(3'b111, 50);

    // Randomized bouncing on all keys with one mid-run reset
    for (int k = 0; k < NK; k++) rem[k] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (rem[k] == 0) begin
          key_n[k] = ~key_n[k];
          case ($urandom_range(0, 3))
            0:       rem[k] = int'($urandom_range(1, 8));
            1:       rem[k] = int'($urandom_range(9, 40));
            2:       rem[k] = int'($urandom_range(41, 150));
            default: rem[k] = int'($urandom_range(100, 220));
          endcase
        end else begin
          rem[k]--;
        end
      end
      if (c == 900) resetPulse(2);
      step();
    end
    applyStimulus(3'b111, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
